im_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle CPU. It receives a framed byte stream from a serial receiver, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction memory through its write port. It holds the CPU in reset while loading and releases it only after the frame checksum verifies. It sits between the serial byte source and the IM write side; the CPU remains the IM reader.

---
 rtl/im_loader.sv | 116 +++++++++++
 tb/tb_im_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Boot-time IM writer: parses a framed byte stream (count, big-endian words, XOR checksum),
// writes each word into instruction memory and holds the CPU in reset until the frame verifies.
module im_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [ADDR_W:0] idx_q,   idx_d;
  logic [31:0]     word_q,  word_d;
  logic [1:0]      bcnt_q,  bcnt_d;
  logic [7:0]      xor_q,   xor_d;
  logic [15:0]     hdr_n;
  logic            accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      xor_q   <= xor_d;
    end
  end

  assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept     = byte_valid && byte_ready;
  assign im_we      = (state_q == S_WRITE);
  assign im_addr    = idx_q[ADDR_W-1:0];
  assign im_wdata   = word_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    xor_d   = xor_q;
    hdr_n   = {count_q[15:8], byte_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          xor_d   = '0;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = byte_data;
          xor_d         = xor_q ^ byte_data;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d = hdr_n;
          xor_d   = xor_q ^ byte_data;
          idx_d   = '0;
          bcnt_d  = '0;
          // Word index is one bit wider than im_addr so a full-capacity frame still terminates.
          if (32'(hdr_n) > (32'd1 << ADDR_W)) state_d = S_ERR;
          else if (hdr_n == 16'd0)            state_d = S_CHK;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], byte_data};
          xor_d  = xor_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if ((32'(idx_q) + 32'd1) == 32'(count_q)) state_d = S_CHK;
        else                                     state_d = S_DATA;
      end
      S_CHK: begin
        if (accept) state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader against a frame-level reference model.
module tb_im_loader;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, im_we, cpu_hold, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  im_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]    frame_q[$];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];

  // im_we is a full-cycle pulse, so it is seen at exactly one falling edge per write
  always @(negedge clock) begin
    if (im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present a byte until it is accepted; returns at the falling edge after the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit hold, input int max_gap);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!byte_ready) chk("ready_timeout", 0, 1);
    @(negedge clock);
    if (!hold) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
    end
  endtask

  // Builds the frame from exp_q, streams it and checks outcome and the write log
  task automatic run_frame(input string tag, input logic [7:0] cks_flip, input bit hold, input int max_gap);
    logic [7:0] x = '0;
    int n = exp_q.size();
    bit ok;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    foreach (exp_q[i]) for (int k = 3; k >= 0; k--) frame_q.push_back(8'(exp_q[i] >> (8 * k)));
    foreach (frame_q[i]) x ^= frame_q[i];
    frame_q.push_back(x ^ cks_flip);
    ok = (cks_flip == 8'h00);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    chk({tag, "_hold_busy"}, cpu_hold, 1);
    chk({tag, "_done_clr"}, done, 0);
    foreach (frame_q[i]) send_byte(frame_q[i], hold, max_gap);
    chk({tag, "_done"}, done, ok);
    chk({tag, "_err"}, err, !ok);
    chk({tag, "_cpu_hold"}, cpu_hold, !ok);
    chk({tag, "_ready_off"}, byte_ready, 0);
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk({tag, "_nwrites"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_q[i], i[AW-1:0]);
      chk({tag, "_data"}, wr_data_q[i], exp_q[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #23;
    check_reset_values("rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_ready", byte_ready, 0);

    // Reference frame: 00 02 3C011234 00221820, checksum 03
    exp_q = '{32'h3C011234, 32'h00221820};
    run_frame("ref_ok", 8'h00, 0, 2);
    run_frame("ref_bad", 8'h07, 0, 2);   // checksum byte 0x04
    exp_q.delete();
    run_frame("empty", 8'h00, 0, 1);

    // Oversized header: 0x0401 words exceeds capacity
    wr_addr_q.delete();
    pulse_start();
    send_byte(8'h04, 0, 0);
    send_byte(8'h01, 0, 0);
    chk("big_err", err, 1);
    chk("big_done", done, 0);
    chk("big_ready", byte_ready, 0);
    chk("big_hold", cpu_hold, 1);
    repeat (2) @(negedge clock);
    chk("big_nwrites", wr_addr_q.size(), 0);

    // Full-capacity frame, valid held high throughout
    exp_q.delete();
    for (int i = 0; i < (1 << AW); i++) exp_q.push_back($urandom);
    run_frame("full", 8'h00, 1, 0);

    // Held-valid stream through WRITE cycles
    exp_q = '{32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A};
    run_frame("hold", 8'h00, 1, 0);

    // Reset mid-session after 6 payload bytes
    wr_addr_q.delete();
    pulse_start();
    send_byte(8'h00, 0, 1);
    send_byte(8'h03, 0, 1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 0, 1);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    chk("midrst_nwrites", wr_addr_q.size(), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    exp_q = '{32'h0BADF00D, 32'h12345678};
    run_frame("after_rst", 8'h00, 0, 2);

    // Randomized frames
    for (int t = 0; t < 10; t++) begin
      int n = $urandom_range(0, 8);
      logic [7:0] flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back($urandom);
      run_frame("rand", flip, bit'($urandom_range(0, 1)), 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end
endmodule
